xconf_loader: RTL and testbench

- Sequencer and arbiter in front of the configuration register bank (xconf).
- Lets the CPU write configuration words directly (pass-through), or start a burst load.
- A burst load fetches a list of (conf address, conf data) word pairs from a memory read port and replays them as xconf control writes with no CPU involvement.
- Sits between the CPU control bus and xconf's ctr_* interface; gives sole write ownership of xconf to one requester at a time.

---
 rtl/xconf_loader.sv | 214 +++++++++++++++++++++
 tb/tb_xconf_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xconf_loader.sv
// xconf_loader: arbitrates xconf write ownership between CPU pass-through and a memory-driven burst loader.
// Optional: define XCONF_LOADER_CLEAR_EN to issue a clear-all write (CLEAR_ADDR, 0) before each burst.

module xconf_loader #(
    parameter int DATA_W      = 32,
    parameter int CONF_ADDR_W = 6,
    parameter int MEM_ADDR_W  = 10,
    parameter int LEN_W       = 8,
    parameter int CLEAR_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctr_valid,
    input  logic                   ctr_we,
    input  logic [CONF_ADDR_W+1:0] ctr_addr,
    input  logic [DATA_W-1:0]      ctr_data_in,
    output logic [DATA_W-1:0]      ctr_data_out,
    output logic                   ctr_ready,
    output logic                   conf_valid,
    output logic                   conf_we,
    output logic [CONF_ADDR_W:0]   conf_addr,
    output logic [DATA_W-1:0]      conf_data,
    output logic                   mem_valid,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic                   done
);

    localparam logic [1:0] REG_BASE   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_GO     = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    if (CLEAR_ADDR < 0 || CLEAR_ADDR >= (1 << (CONF_ADDR_W + 1))) begin : g_bad_clear_addr
        $error("CLEAR_ADDR does not fit in the xconf address");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_D = 3'd2,
        S_WRITE   = 3'd3,
        S_FIN     = 3'd4
`ifdef XCONF_LOADER_CLEAR_EN
        , S_CLEAR = 3'd5
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [MEM_ADDR_W-1:0]  base_q, base_d, ptr_q, ptr_d;
    logic [LEN_W-1:0]       len_q, len_d, cnt_q, cnt_d;
    logic                   err_q, err_d, done_q, done_d;
    logic [CONF_ADDR_W:0]   pair_addr_q, pair_addr_d;
    logic                   conf_valid_q, conf_valid_d, conf_we_q, conf_we_d;
    logic [CONF_ADDR_W:0]   conf_addr_q, conf_addr_d;
    logic [DATA_W-1:0]      conf_data_q, conf_data_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d, rd_mux;

    logic busy, reg_sel, pass_sel, reg_wr, reg_rd;

    assign busy      = (state_q != S_IDLE);
    assign reg_sel   = ctr_valid & ctr_addr[CONF_ADDR_W+1];
    assign pass_sel  = ctr_valid & ~ctr_addr[CONF_ADDR_W+1];
    assign reg_wr    = reg_sel & ctr_we;
    assign reg_rd    = reg_sel & ~ctr_we;
    assign ctr_ready = reg_sel | (pass_sel & ~busy);

    always_comb begin
        case (ctr_addr[1:0])
            REG_BASE:   rd_mux = DATA_W'(base_q);
            REG_LEN:    rd_mux = DATA_W'(len_q);
            REG_STATUS: rd_mux = DATA_W'({err_q, busy});
            default:    rd_mux = '0;
        endcase
    end

    // Read data is visible in the accepting cycle and then held by rdata_q.
    assign ctr_data_out = reg_rd ? rd_mux : rdata_q;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        pair_addr_d  = pair_addr_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        conf_valid_d = 1'b0;
        conf_we_d    = 1'b0;
        conf_addr_d  = '0;
        conf_data_d  = '0;
        mem_valid    = 1'b0;
        mem_addr     = '0;

        case (state_q)
            S_FETCH_A: begin
                mem_valid = 1'b1;
                mem_addr  = ptr_q;
                if (mem_ready) begin
                    pair_addr_d = mem_rdata[CONF_ADDR_W:0];
                    ptr_d       = ptr_q + 1'b1;
                    state_d     = S_FETCH_D;
                end
            end
            S_FETCH_D: begin
                mem_valid = 1'b1;
                mem_addr  = ptr_q;
                if (mem_ready) begin
                    conf_valid_d = 1'b1;
                    conf_we_d    = 1'b1;
                    conf_addr_d  = pair_addr_q;
                    conf_data_d  = mem_rdata;
                    ptr_d        = ptr_q + 1'b1;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d != '0) begin
                    state_d = S_FETCH_A;
                end else begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_FIN: state_d = S_IDLE;
`ifdef XCONF_LOADER_CLEAR_EN
            S_CLEAR: state_d = S_FETCH_A;
`endif
            default: state_d = S_IDLE;
        endcase

        if (reg_rd) rdata_d = rd_mux;

        if (reg_wr) begin
            case (ctr_addr[1:0])
                REG_BASE: if (!busy) base_d = ctr_data_in[MEM_ADDR_W-1:0];
                REG_LEN:  if (!busy) len_d = ctr_data_in[LEN_W-1:0];
                REG_GO: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d = len_q;
                        ptr_d = base_q;
`ifdef XCONF_LOADER_CLEAR_EN
                        state_d      = S_CLEAR;
                        conf_valid_d = 1'b1;
                        conf_we_d    = 1'b1;
                        conf_addr_d  = (CONF_ADDR_W+1)'(CLEAR_ADDR);
                        conf_data_d  = '0;
`else
                        state_d = S_FETCH_A;
`endif
                    end
                end
                default: if (ctr_data_in[1]) err_d = 1'b0;
            endcase
        end

        if (pass_sel && !busy) begin
            conf_valid_d = 1'b1;
            conf_we_d    = ctr_we;
            conf_addr_d  = ctr_addr[CONF_ADDR_W:0];
            conf_data_d  = ctr_data_in;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: datapath flops are reset too, so a reset mid-burst leaves no stale strobe or data on any output.
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            pair_addr_q  <= '0;
            conf_valid_q <= 1'b0;
            conf_we_q    <= 1'b0;
            conf_addr_q  <= '0;
            conf_data_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            done_q       <= done_d;
            pair_addr_q  <= pair_addr_d;
            conf_valid_q <= conf_valid_d;
            conf_we_q    <= conf_we_d;
            conf_addr_q  <= conf_addr_d;
            conf_data_q  <= conf_data_d;
            rdata_q      <= rdata_d;
        end
    end

    assign conf_valid = conf_valid_q;
    assign conf_we    = conf_we_q;
    assign conf_addr  = conf_addr_q;
    assign conf_data  = conf_data_q;
    assign done       = done_q;

endmodule

// File: tb/tb_xconf_loader.sv
// Self-checking bench for xconf_loader: register/pass-through vector table, directed burst corner cases,
// and randomized bursts compared against a list-replay model with arithmetic timing.
`timescale 1ns/1ps

module tb_xconf_loader;

    localparam int DATA_W      = 32;
    localparam int CONF_ADDR_W = 6;
    localparam int MEM_ADDR_W  = 10;
    localparam int LEN_W       = 8;
    localparam int CLEAR_ADDR  = 0;
`ifdef XCONF_LOADER_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ctr_valid, ctr_we;
    logic [7:0]  ctr_addr;
    logic [31:0] ctr_data_in, ctr_data_out;
    logic        ctr_ready;
    logic        conf_valid, conf_we;
    logic [6:0]  conf_addr;
    logic [31:0] conf_data;
    logic        mem_valid, mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        done;

    xconf_loader #(
        .DATA_W(DATA_W), .CONF_ADDR_W(CONF_ADDR_W), .MEM_ADDR_W(MEM_ADDR_W),
        .LEN_W(LEN_W), .CLEAR_ADDR(CLEAR_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .ctr_valid(ctr_valid), .ctr_we(ctr_we), .ctr_addr(ctr_addr),
        .ctr_data_in(ctr_data_in), .ctr_data_out(ctr_data_out), .ctr_ready(ctr_ready),
        .conf_valid(conf_valid), .conf_we(conf_we), .conf_addr(conf_addr), .conf_data(conf_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] data;
        int          cyc;
    } cw_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        is_rd;
        logic [31:0] exp_rd;
        logic        exp_cv;
        logic        exp_cwe;
        logic [6:0]  exp_ca;
        logic [31:0] exp_cd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // List memory with a programmable number of wait cycles per fetch.
    logic [31:0] mem [0:1023];
    int mem_wait = 0;
    int wait_cnt = 0;
    always @(posedge clk) wait_cnt <= (mem_valid && !mem_ready) ? wait_cnt + 1 : 0;
    assign mem_ready = mem_valid && (wait_cnt >= mem_wait);
    assign mem_rdata = mem_ready ? mem[mem_addr] : 32'hDEAD_BEEF;

    int          cyc = 0;
    cw_t         conf_log[$];
    int          done_log[$];
    logic [9:0]  fetch_log[$];
    int          mem_cycles = 0;
    int          addr_jumps = 0;
    logic        prev_wait = 1'b0;
    logic [9:0]  prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (conf_valid) conf_log.push_back('{conf_we, conf_addr, conf_data, cyc});
        if (done) done_log.push_back(cyc);
        if (mem_valid) mem_cycles <= mem_cycles + 1;
        if (mem_valid && mem_ready) fetch_log.push_back(mem_addr);
        if (mem_valid && prev_wait && mem_addr !== prev_addr) addr_jumps <= addr_jumps + 1;
        prev_wait <= mem_valid && !mem_ready;
        prev_addr <= mem_addr;
    end

    cw_t        exp_q[$];
    logic [9:0] fexp_q[$];

    // Called just after a rising edge; drives one request cycle and returns just after the next edge.
    task automatic cpu_cycle(input logic we, input logic [7:0] addr, input logic [31:0] data,
                             output logic rdy, output logic [31:0] rd);
        ctr_valid = 1'b1; ctr_we = we; ctr_addr = addr; ctr_data_in = data;
        @(negedge clk);
        rdy = ctr_ready;
        rd  = ctr_data_out;
        @(posedge clk); #1;
        ctr_valid = 1'b0; ctr_we = 1'b0; ctr_addr = '0; ctr_data_in = '0;
    endtask

    task automatic reg_wr(input logic [1:0] sel, input logic [31:0] data);
        logic r;
        logic [31:0] d;
        cpu_cycle(1'b1, {1'b1, 5'd0, sel}, data, r, d);
        check($sformatf("reg write %0d ready", sel), 64'(r), 64'd1);
    endtask

    task automatic reg_rd(input logic [1:0] sel, output logic [31:0] d);
        logic r;
        cpu_cycle(1'b0, {1'b1, 5'd0, sel}, 32'h0, r, d);
        check($sformatf("reg read %0d ready", sel), 64'(r), 64'd1);
    endtask

    task automatic wait_done_from(input int d0, input int budget, input string name);
        int n = 0;
        while (done_log.size() <= d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " done within budget"}, 64'(done_log.size() > d0), 64'd1);
    endtask

    // Expected replay: pair i comes from words base+2i, base+2i+1 (mod 1024) and is written
    // (i+1) pair periods after GO, one period being two fetches plus the write cycle.
    task automatic build_model(input int base, input int len, input int w, input int go_cyc);
        int per, a;
        logic [31:0] word;
        per = 2 * (1 + w) + 1;
        if (CLR != 0) exp_q.push_back('{1'b1, 7'(CLEAR_ADDR), 32'h0, go_cyc + 1});
        for (int i = 0; i < len; i++) begin
            a = (base + 2 * i) % 1024;
            word = mem[a];
            exp_q.push_back('{1'b1, word[6:0], mem[(a + 1) % 1024], go_cyc + CLR + (i + 1) * per});
            fexp_q.push_back(10'(a));
            fexp_q.push_back(10'((a + 1) % 1024));
        end
    endtask

    task automatic compare_log(input int c0, input int f0, input int j0, input string name);
        check({name, " conf write count"}, 64'(conf_log.size() - c0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i < conf_log.size()) begin
                check($sformatf("%s w%0d we", name, i), 64'(conf_log[c0+i].we), 64'(exp_q[i].we));
                check($sformatf("%s w%0d addr", name, i), 64'(conf_log[c0+i].addr), 64'(exp_q[i].addr));
                check($sformatf("%s w%0d data", name, i), 64'(conf_log[c0+i].data), 64'(exp_q[i].data));
                check($sformatf("%s w%0d cycle", name, i), 64'(conf_log[c0+i].cyc), 64'(exp_q[i].cyc));
            end
        end
        check({name, " fetch count"}, 64'(fetch_log.size() - f0), 64'(fexp_q.size()));
        for (int i = 0; i < fexp_q.size(); i++) begin
            if (f0 + i < fetch_log.size())
                check($sformatf("%s fetch%0d addr", name, i), 64'(fetch_log[f0+i]), 64'(fexp_q[i]));
        end
        check({name, " mem_addr stable while waiting"}, 64'(addr_jumps - j0), 64'd0);
    endtask

    task automatic run_burst(input int base, input int len, input int w, input bit pre_pass, input string name);
        int go_cyc, c0, d0, f0, m0, j0;
        logic r;
        logic [31:0] rd;
        cw_t pass;
        mem_wait = w;
        reg_wr(2'd0, 32'(base));
        reg_wr(2'd1, 32'(len));
        c0 = conf_log.size(); d0 = done_log.size(); f0 = fetch_log.size();
        m0 = mem_cycles; j0 = addr_jumps;
        exp_q.delete(); fexp_q.delete();
        if (pre_pass) begin
            pass = '{1'b1, 7'($urandom), $urandom, cyc + 1};
            cpu_cycle(1'b1, {1'b0, pass.addr}, pass.data, r, rd);
            check({name, " pre-GO pass ready"}, 64'(r), 64'd1);
            exp_q.push_back(pass);
        end
        go_cyc = cyc;
        reg_wr(2'd2, 32'h0);
        build_model(base, len, w, go_cyc);
        wait_done_from(d0, len * (2 * (1 + w) + 1) + 50, name);
        repeat (2) @(posedge clk);
        #1;
        compare_log(c0, f0, j0, name);
        check({name, " done pulses"}, 64'(done_log.size() - d0), 64'd1);
        if (done_log.size() > d0)
            check({name, " done cycle"}, 64'(done_log[d0]), 64'(exp_q[exp_q.size()-1].cyc + 1));
        check({name, " mem_valid cycles"}, 64'(mem_cycles - m0), 64'(len * 2 * (1 + w)));
        reg_rd(2'd3, rd);
        check({name, " STATUS after"}, 64'(rd), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[12];
        logic        r;
        logic [31:0] rd, last_rd;
        int          go_cyc, c0, d0, f0, m0, j0, acc, n, last_w;

        vt[0]  = '{1'b1, 8'h05, 32'h0000_03FF, 1'b0, 32'h0,     1'b1, 1'b1, 7'h05, 32'h0000_03FF};
        vt[1]  = '{1'b0, 8'h2A, 32'h0000_1234, 1'b0, 32'h0,     1'b1, 1'b0, 7'h2A, 32'h0000_1234};
        vt[2]  = '{1'b1, 8'h7F, 32'hCAFE_F00D, 1'b0, 32'h0,     1'b1, 1'b1, 7'h7F, 32'hCAFE_F00D};
        vt[3]  = '{1'b1, 8'h80, 32'h0000_0123, 1'b0, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};
        vt[4]  = '{1'b1, 8'h81, 32'hFFFF_FF07, 1'b0, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};
        vt[5]  = '{1'b0, 8'h80, 32'h0,         1'b1, 32'h123,   1'b0, 1'b0, 7'h00, 32'h0};
        vt[6]  = '{1'b0, 8'h81, 32'h0,         1'b1, 32'h07,    1'b0, 1'b0, 7'h00, 32'h0};
        vt[7]  = '{1'b0, 8'h83, 32'h0,         1'b1, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};
        vt[8]  = '{1'b1, 8'h80, 32'hFFFF_FFFF, 1'b0, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};
        vt[9]  = '{1'b0, 8'hBC, 32'h0,         1'b1, 32'h3FF,   1'b0, 1'b0, 7'h00, 32'h0};
        vt[10] = '{1'b1, 8'h83, 32'h0000_0002, 1'b0, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};
        vt[11] = '{1'b0, 8'h87, 32'h0,         1'b1, 32'h0,     1'b0, 1'b0, 7'h00, 32'h0};

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1; ctr_valid = 1'b0; ctr_we = 1'b0; ctr_addr = '0; ctr_data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset conf_valid", 64'(conf_valid), 64'd0);
        check("reset conf_we", 64'(conf_we), 64'd0);
        check("reset conf_addr", 64'(conf_addr), 64'd0);
        check("reset conf_data", 64'(conf_data), 64'd0);
        check("reset mem_valid", 64'(mem_valid), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset ctr_ready", 64'(ctr_ready), 64'd0);
        check("reset ctr_data_out", 64'(ctr_data_out), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        last_rd = 32'h0;
        for (int i = 0; i < 12; i++) begin
            cpu_cycle(vt[i].we, vt[i].addr, vt[i].data, r, rd);
            check($sformatf("vec%0d ready", i), 64'(r), 64'd1);
            if (vt[i].is_rd) begin
                check($sformatf("vec%0d read data", i), 64'(rd), 64'(vt[i].exp_rd));
                last_rd = vt[i].exp_rd;
            end
            @(negedge clk);
            check($sformatf("vec%0d conf_valid", i), 64'(conf_valid), 64'(vt[i].exp_cv));
            check($sformatf("vec%0d conf_we", i), 64'(conf_we), 64'(vt[i].exp_cwe));
            check($sformatf("vec%0d conf_addr", i), 64'(conf_addr), 64'(vt[i].exp_ca));
            check($sformatf("vec%0d conf_data", i), 64'(conf_data), 64'(vt[i].exp_cd));
            check($sformatf("vec%0d read data held", i), 64'(ctr_data_out), 64'(last_rd));
            @(posedge clk); #1;
        end

        mem[16] = 32'h3; mem[17] = 32'hAA; mem[18] = 32'h7; mem[19] = 32'h55;
        run_burst(16, 2, 0, 1'b0, "burst");
        run_burst(16, 2, 4, 1'b0, "waits");
        mem[1023] = 32'h12; mem[0] = 32'h0000_BEEF;
        run_burst(1023, 1, 0, 1'b0, "wrap");

        // LEN=0: done only, no fetch and no conf traffic.
        reg_wr(2'd1, 32'h0);
        c0 = conf_log.size(); d0 = done_log.size(); m0 = mem_cycles;
        go_cyc = cyc;
        reg_wr(2'd2, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("len0 done pulses", 64'(done_log.size() - d0), 64'd1);
        if (done_log.size() > d0) check("len0 done cycle", 64'(done_log[d0]), 64'(go_cyc + 1));
        check("len0 mem_valid cycles", 64'(mem_cycles - m0), 64'd0);
        check("len0 conf writes", 64'(conf_log.size() - c0), 64'd0);

        // Busy contention: GO, BASE/LEN writes and pass-through while a slow burst runs.
        mem_wait = 4;
        reg_wr(2'd0, 32'h40);
        reg_wr(2'd1, 32'h3);
        c0 = conf_log.size(); d0 = done_log.size(); f0 = fetch_log.size(); j0 = addr_jumps;
        exp_q.delete(); fexp_q.delete();
        go_cyc = cyc;
        reg_wr(2'd2, 32'h0);
        build_model(64, 3, 4, go_cyc);
        last_w = exp_q[exp_q.size()-1].cyc;
        reg_wr(2'd2, 32'h0);
        reg_rd(2'd3, rd);
        check("busy GO sets ERR", 64'(rd), 64'h3);
        reg_wr(2'd3, 32'h2);
        reg_rd(2'd3, rd);
        check("ERR cleared while busy", 64'(rd), 64'h1);
        reg_wr(2'd0, 32'h155);
        reg_wr(2'd1, 32'h9);
        ctr_valid = 1'b1; ctr_we = 1'b1; ctr_addr = 8'h15; ctr_data_in = 32'h600D_CAFE;
        acc = -1; n = 0;
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            if (ctr_ready) acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        ctr_valid = 1'b0; ctr_we = 1'b0; ctr_addr = '0; ctr_data_in = '0;
        check("busy pass accepted", 64'(acc >= 0), 64'd1);
        check("busy pass accept cycle", 64'(acc), 64'(last_w + 2));
        exp_q.push_back('{1'b1, 7'h15, 32'h600D_CAFE, acc + 1});
        repeat (2) @(posedge clk);
        #1;
        compare_log(c0, f0, j0, "busy");
        check("busy done pulses", 64'(done_log.size() - d0), 64'd1);
        reg_rd(2'd0, rd);
        check("BASE write ignored while busy", 64'(rd), 64'h40);
        reg_rd(2'd1, rd);
        check("LEN write ignored while busy", 64'(rd), 64'h3);
        reg_rd(2'd3, rd);
        check("busy STATUS after", 64'(rd), 64'h0);

        // Reset during a burst write cycle.
        mem_wait = 0;
        reg_wr(2'd0, 32'h10);
        reg_wr(2'd1, 32'h2);
        reg_wr(2'd2, 32'h0);
        n = 0;
        @(negedge clk);
        while (!conf_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst test reached a conf write", 64'(conf_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst mid conf_valid", 64'(conf_valid), 64'd0);
        check("rst mid conf_we", 64'(conf_we), 64'd0);
        check("rst mid conf_addr", 64'(conf_addr), 64'd0);
        check("rst mid conf_data", 64'(conf_data), 64'd0);
        check("rst mid mem_valid", 64'(mem_valid), 64'd0);
        check("rst mid mem_addr", 64'(mem_addr), 64'd0);
        check("rst mid done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = conf_log.size(); d0 = done_log.size(); m0 = mem_cycles;
        repeat (10) @(posedge clk);
        #1;
        check("rst no conf after", 64'(conf_log.size() - c0), 64'd0);
        check("rst no done after", 64'(done_log.size() - d0), 64'd0);
        check("rst no mem after", 64'(mem_cycles - m0), 64'd0);
        reg_rd(2'd0, rd);
        check("rst BASE cleared", 64'(rd), 64'd0);
        reg_rd(2'd1, rd);
        check("rst LEN cleared", 64'(rd), 64'd0);
        reg_rd(2'd3, rd);
        check("rst STATUS cleared", 64'(rd), 64'd0);

        for (int k = 0; k < 20; k++) begin
            run_burst(int'($urandom_range(0, 1023)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
